// File: rtl/hilo_acc_pkg.sv
// Shared defines for the HI/LO accumulator: operation encodings, default width
// and the zero-word constant used for reset values.
package hilo_acc_pkg;

    localparam int HILO_WIDTH = 32;

    localparam logic [HILO_WIDTH-1:0] HILO_ZERO = '0;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_MADD  = 2'b01,
        OP_MSUB  = 2'b10,
        OP_RSVD  = 2'b11
    } op_mode_e;

endpackage

// File: rtl/hilo_addsub.sv
// WIDTH-bit adder/subtractor with carry/borrow in and out; one instance per
// half of the HI/LO pair.
module hilo_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] y,
    output logic             cout
);

    logic [WIDTH:0] ext;

    // In subtract mode cin/cout act as borrow: a negative result sets the top bit.
    always_comb begin
        ext = '0;
        if (sub)
            ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        else
            ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        y    = ext[WIDTH-1:0];
        cout = ext[WIDTH];
    end

endmodule

// File: rtl/hilo_acc.sv
// HI/LO register pair with direct writes and two-cycle MADD/MSUB accumulation.
// Optional macro HILO_BYPASS_EN forwards accepted write data to hi_o/lo_o.
import hilo_acc_pkg::*;

module hilo_acc #(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_mode,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             done
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACC_HI = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_opnd;
    logic             carry_q;
    logic             sub_q;
    logic [WIDTH-1:0] lo_y;
    logic             lo_cout;
    logic [WIDTH-1:0] hi_y;
    logic             hi_cout_unused;

    assign op_ready = (state == ST_IDLE);

    hilo_addsub #(.WIDTH(WIDTH)) u_lo (
        .a    (lo_q),
        .b    (lo_i),
        .cin  (1'b0),
        .sub  (op_mode == OP_MSUB),
        .y    (lo_y),
        .cout (lo_cout)
    );

    // The HI half consumes the operand, carry/borrow and direction latched at accept.
    hilo_addsub #(.WIDTH(WIDTH)) u_hi (
        .a    (hi_q),
        .b    (hi_opnd),
        .cin  (carry_q),
        .sub  (sub_q),
        .y    (hi_y),
        .cout (hi_cout_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            hi_q    <= WIDTH'(HILO_ZERO);
            lo_q    <= WIDTH'(HILO_ZERO);
            hi_opnd <= WIDTH'(HILO_ZERO);
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_mode)
                            OP_WRITE: begin
                                if (hi_we) hi_q <= hi_i;
                                if (lo_we) lo_q <= lo_i;
                            end
                            OP_MADD, OP_MSUB: begin
                                lo_q    <= lo_y;
                                carry_q <= lo_cout;
                                hi_opnd <= hi_i;
                                sub_q   <= (op_mode == OP_MSUB);
                                state   <= ST_ACC_HI;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ACC_HI: begin
                    hi_q  <= hi_y;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HILO_BYPASS_EN
    logic wr_accept;
    assign wr_accept = op_valid && op_ready && (op_mode == OP_WRITE);
    assign hi_o = (wr_accept && hi_we) ? hi_i : hi_q;
    assign lo_o = (wr_accept && lo_we) ? lo_i : lo_q;
`else
    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_acc.sv
// Directed self-checking bench for hilo_acc (WIDTH=32); bypass expectations
// follow HILO_BYPASS_EN.
module tb_hilo_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_mode = 2'b00;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        done;

    int n_compared = 0;
    int n_mismatched = 0;

    hilo_acc #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_mode  (op_mode),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_compared++; if (hi_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_hi: got %h want %h", hi_o, 32'h0); end
        n_compared++; if (lo_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_lo: got %h want %h", lo_o, 32'h0); end
        n_compared++; if (op_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b want 1", op_ready); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    endtask

    task automatic test_write();
        op_valid = 1'b1; op_mode = 2'b00; hi_we = 1'b1; lo_we = 1'b1;
        hi_i = 32'h12345678; lo_i = 32'h9ABCDEF0;
        step();
        op_valid = 1'b0;
        n_compared++; if (hi_o !== 32'h12345678) begin n_mismatched++; $display("[TB] FAIL write_both_hi: got %h want %h", hi_o, 32'h12345678); end
        n_compared++; if (lo_o !== 32'h9ABCDEF0) begin n_mismatched++; $display("[TB] FAIL write_both_lo: got %h want %h", lo_o, 32'h9ABCDEF0); end
        op_valid = 1'b1; hi_we = 1'b1; lo_we = 1'b0;
        hi_i = 32'hAAAAAAAA; lo_i = 32'hDEADBEEF;
        step();
        op_valid = 1'b0;
        n_compared++; if (hi_o !== 32'hAAAAAAAA) begin n_mismatched++; $display("[TB] FAIL write_hi_only_hi: got %h want %h", hi_o, 32'hAAAAAAAA); end
        n_compared++; if (lo_o !== 32'h9ABCDEF0) begin n_mismatched++; $display("[TB] FAIL write_hi_only_lo: got %h want %h", lo_o, 32'h9ABCDEF0); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL write_done: got %b want 0", done); end
    endtask

    task automatic test_madd();
        op_valid = 1'b1; op_mode = 2'b00; hi_we = 1'b1; lo_we = 1'b1;
        hi_i = 32'h0; lo_i = 32'hFFFFFFFF;
        step();
        // Enables set on purpose: MADD must ignore them.
        op_mode = 2'b01; hi_i = 32'h0; lo_i = 32'h1;
        step();
        // Inputs presented while busy must be ignored.
        op_mode = 2'b00; hi_we = 1'b1; lo_we = 1'b1; hi_i = 32'h77; lo_i = 32'h88;
        n_compared++; if (lo_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL madd_e1_lo: got %h want %h", lo_o, 32'h0); end
        n_compared++; if (hi_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL madd_e1_hi: got %h want %h", hi_o, 32'h0); end
        n_compared++; if (op_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL madd_e1_ready: got %b want 0", op_ready); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL madd_e1_done: got %b want 0", done); end
        step();
        op_valid = 1'b0;
        n_compared++; if (hi_o !== 32'h1) begin n_mismatched++; $display("[TB] FAIL madd_e2_hi: got %h want %h", hi_o, 32'h1); end
        n_compared++; if (lo_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL madd_e2_lo: got %h want %h", lo_o, 32'h0); end
        n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL madd_e2_done: got %b want 1", done); end
        n_compared++; if (op_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL madd_e2_ready: got %b want 1", op_ready); end
        step();
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL madd_done_pulse: got %b want 0", done); end
        n_compared++; if (hi_o !== 32'h1) begin n_mismatched++; $display("[TB] FAIL madd_hold_hi: got %h want %h", hi_o, 32'h1); end
    endtask

    task automatic test_msub();
        op_valid = 1'b1; op_mode = 2'b00; hi_we = 1'b1; lo_we = 1'b1;
        hi_i = 32'h0; lo_i = 32'h0;
        step();
        op_mode = 2'b10; hi_we = 1'b0; lo_we = 1'b0; hi_i = 32'h0; lo_i = 32'h1;
        step();
        op_valid = 1'b0;
        n_compared++; if (lo_o !== 32'hFFFFFFFF) begin n_mismatched++; $display("[TB] FAIL msub_e1_lo: got %h want %h", lo_o, 32'hFFFFFFFF); end
        n_compared++; if (op_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL msub_e1_ready: got %b want 0", op_ready); end
        step();
        n_compared++; if (hi_o !== 32'hFFFFFFFF) begin n_mismatched++; $display("[TB] FAIL msub_e2_hi: got %h want %h", hi_o, 32'hFFFFFFFF); end
        n_compared++; if (lo_o !== 32'hFFFFFFFF) begin n_mismatched++; $display("[TB] FAIL msub_e2_lo: got %h want %h", lo_o, 32'hFFFFFFFF); end
        n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL msub_e2_done: got %b want 1", done); end
        step();
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL msub_done_pulse: got %b want 0", done); end
    endtask

    // {1,80000000} + {2,80000001} = {4,00000001}; then - {0,2} = {3,FFFFFFFF}.
    task automatic test_back_to_back();
        op_valid = 1'b1; op_mode = 2'b00; hi_we = 1'b1; lo_we = 1'b1;
        hi_i = 32'h1; lo_i = 32'h80000000;
        step();
        op_mode = 2'b01; hi_we = 1'b0; lo_we = 1'b0; hi_i = 32'h2; lo_i = 32'h80000001;
        step();
        op_mode = 2'b10; hi_i = 32'h0; lo_i = 32'h2;
        n_compared++; if (lo_o !== 32'h00000001) begin n_mismatched++; $display("[TB] FAIL b2b_madd_lo: got %h want %h", lo_o, 32'h00000001); end
        step();
        n_compared++; if (hi_o !== 32'h4) begin n_mismatched++; $display("[TB] FAIL b2b_madd_hi: got %h want %h", hi_o, 32'h4); end
        n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_madd_done: got %b want 1", done); end
        n_compared++; if (op_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_ready: got %b want 1", op_ready); end
        step();
        op_valid = 1'b0;
        n_compared++; if (op_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_msub_accepted: got %b want 0", op_ready); end
        n_compared++; if (lo_o !== 32'hFFFFFFFF) begin n_mismatched++; $display("[TB] FAIL b2b_msub_lo: got %h want %h", lo_o, 32'hFFFFFFFF); end
        step();
        n_compared++; if (hi_o !== 32'h3) begin n_mismatched++; $display("[TB] FAIL b2b_msub_hi: got %h want %h", hi_o, 32'h3); end
        n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_msub_done: got %b want 1", done); end
    endtask

    task automatic test_reserved();
        op_valid = 1'b1; op_mode = 2'b11; hi_we = 1'b1; lo_we = 1'b1;
        hi_i = 32'h11111111; lo_i = 32'h22222222;
        step();
        op_valid = 1'b0;
        n_compared++; if (hi_o !== 32'h3) begin n_mismatched++; $display("[TB] FAIL rsvd_hi: got %h want %h", hi_o, 32'h3); end
        n_compared++; if (lo_o !== 32'hFFFFFFFF) begin n_mismatched++; $display("[TB] FAIL rsvd_lo: got %h want %h", lo_o, 32'hFFFFFFFF); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rsvd_done: got %b want 0", done); end
        n_compared++; if (op_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rsvd_ready: got %b want 1", op_ready); end
    endtask

    task automatic test_reset_in_acc();
        op_valid = 1'b1; op_mode = 2'b01; hi_we = 1'b0; lo_we = 1'b0;
        hi_i = 32'h5; lo_i = 32'h7;
        step();
        op_valid = 1'b0;
        n_compared++; if (op_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstacc_busy: got %b want 0", op_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_compared++; if (hi_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rstacc_hi: got %h want %h", hi_o, 32'h0); end
        n_compared++; if (lo_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rstacc_lo: got %h want %h", lo_o, 32'h0); end
        n_compared++; if (op_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstacc_ready: got %b want 1", op_ready); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstacc_done: got %b want 0", done); end
        step();
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rstacc_done_late: got %b want 0", done); end
        n_compared++; if (hi_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rstacc_hi_late: got %h want %h", hi_o, 32'h0); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_hi;
`ifdef HILO_BYPASS_EN
        exp_hi = 32'h5;
`else
        exp_hi = 32'h0;
`endif
        op_valid = 1'b1; op_mode = 2'b00; hi_we = 1'b1; lo_we = 1'b0;
        hi_i = 32'h5; lo_i = 32'h9;
        #1;
        n_compared++; if (hi_o !== exp_hi) begin n_mismatched++; $display("[TB] FAIL bypass_same_cycle_hi: got %h want %h", hi_o, exp_hi); end
        n_compared++; if (lo_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL bypass_same_cycle_lo: got %h want %h", lo_o, 32'h0); end
        step();
        op_valid = 1'b0;
        n_compared++; if (hi_o !== 32'h5) begin n_mismatched++; $display("[TB] FAIL bypass_next_hi: got %h want %h", hi_o, 32'h5); end
        n_compared++; if (lo_o !== 32'h0) begin n_mismatched++; $display("[TB] FAIL bypass_next_lo: got %h want %h", lo_o, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_madd();
        test_msub();
        test_back_to_back();
        test_reserved();
        test_reset_in_acc();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/hilo_acc.md
HILO_ACC -- requirements
Module: hilo_acc

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the bit width of each of HI and LO.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 The module SHALL have port op_valid, input, 1, an operation request.
REQ-005 The module SHALL have port op_ready, output, 1, high when a request is accepted this cycle.
REQ-006 The module SHALL have port op_mode, input, 2: 00 write, 01 MADD, 10 MSUB, 11 reserved.
REQ-007 The module SHALL have port hi_we, input, 1, the HI write enable (write mode only).
REQ-008 The module SHALL have port lo_we, input, 1, the LO write enable (write mode only).
REQ-009 The module SHALL have port hi_i, input, WIDTH: write data, or the upper product half in MADD/MSUB.
REQ-010 The module SHALL have port lo_i, input, WIDTH: write data, or the lower product half in MADD/MSUB.
REQ-011 The module SHALL have port hi_o, output, WIDTH, the HI read value.
REQ-012 The module SHALL have port lo_o, output, WIDTH, the LO read value.
REQ-013 The module SHALL have port done, output, 1, a one-cycle pulse when a MADD/MSUB completes.

Function
REQ-014 The module SHALL accept a request on a rising edge where op_valid and op_ready are both 1; op_ready SHALL be 1 exactly in state IDLE.
REQ-015 The module SHALL implement states IDLE and ACC_HI; reset state is IDLE.
REQ-016 A write-mode accept SHALL update HI from hi_i if hi_we, and LO from lo_i if lo_we, at that edge; an unenabled half is unchanged; state stays IDLE.
REQ-017 A MADD accept SHALL, at that edge: lo <= lo + lo_i (mod 2^WIDTH); latch the carry-out and hi_i; state -> ACC_HI.
REQ-018 In ACC_HI after MADD, the next edge SHALL set hi <= hi + latched hi_i + carry (mod 2^WIDTH), assert done for one cycle and return to IDLE.
REQ-019 MSUB SHALL follow the same two steps with subtraction and borrow: result {hi,lo} = {hi,lo} - {hi_i,lo_i} mod 2^(2*WIDTH).
REQ-020 MADD/MSUB SHALL ignore hi_we and lo_we.
REQ-021 MADD/MSUB latency SHALL be 2 cycles from accept to final HI; op_ready SHALL be 0 for exactly 1 cycle; a back-to-back request in the following IDLE cycle SHALL be accepted.
REQ-022 A reserved-mode (11) accept SHALL change no state and SHALL NOT assert done.
REQ-023 Inputs presented in ACC_HI SHALL be ignored.

Reset
REQ-024 While rst is 1 at a rising edge, HI and LO SHALL be set to 0, the state to IDLE, done to 0, and the latched carry/operand to 0; rst SHALL take priority over every operation.
REQ-025 A reset arriving in ACC_HI SHALL abandon the operation: no done pulse, and HI/LO reset to 0.

Configuration
REQ-026 When macro HILO_BYPASS_EN is defined, hi_o/lo_o SHALL forward hi_i/lo_i combinationally in any cycle with an accepted write-mode request whose corresponding enable is 1; otherwise they SHALL show the register values.
REQ-027 When HILO_BYPASS_EN is undefined, hi_o/lo_o SHALL always be the register values; a write becomes visible the cycle after the edge.
REQ-028 No bypass SHALL exist for MADD/MSUB intermediate or final values in either configuration.

Structure
REQ-029 The op_mode encodings, the default WIDTH, and the zero-word constant SHALL live in the shared defines file.
REQ-030 A sub-module hilo_addsub SHALL provide a WIDTH-bit add/subtract with carry/borrow in and out, used for both halves.

Verification
REQ-031 Case 1 (WIDTH=32): reset, then write mode with hi_we=lo_we=1, hi_i=0x12345678, lo_i=0x9ABCDEF0 -> next cycle hi_o=0x12345678, lo_o=0x9ABCDEF0.
REQ-032 Case 2: then write mode with hi_we=1, lo_we=0, hi_i=0xAAAAAAAA -> hi_o=0xAAAAAAAA, lo_o stays 0x9ABCDEF0.
REQ-033 Case 3: HI=0, LO=0xFFFFFFFF; MADD with hi_i=0, lo_i=1 -> after edge 1 lo_o=0 and op_ready=0; after edge 2 hi_o=1 and done=1 for one cycle.
REQ-034 Case 4: HI=LO=0; MSUB with hi_i=0, lo_i=1 -> final hi_o=lo_o=0xFFFFFFFF and one done pulse.
REQ-035 Case 5: start a MADD, assert rst in ACC_HI -> hi_o=lo_o=0, op_ready=1 next cycle, done never asserted.
REQ-036 Case 6: write hi_i=0x5 with hi_we=1 -> same cycle hi_o=0x5 with HILO_BYPASS_EN, previous value without it.
